// File: rtl/xike_pkg.sv
// Shared constants, state encoding and tag-slicing helper for the raw frame path.
//   N_STREAMS     : number of combined streams per beat
//   DW / CW       : sample / channel-tag width per stream
//   CH_PER_STREAM : samples per stream per frame (power of 2)
package xike_pkg;

  localparam int unsigned N_STREAMS     = 5;
  localparam int unsigned DW            = 16;
  localparam int unsigned CW            = 12;
  localparam int unsigned CH_PER_STREAM = 32;

  localparam int unsigned IW     = $clog2(CH_PER_STREAM);
  localparam int unsigned DATA_W = N_STREAMS * DW;
  localparam int unsigned CH_W   = N_STREAMS * CW;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ERR_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Channel tag of stream k from the packed {chN-1..ch0} bus.
  function automatic logic [CW-1:0] get_tag(input logic [CH_W-1:0] ch,
                                            input int unsigned     k);
    return ch[k*CW +: CW];
  endfunction

endpackage

// File: rtl/raw_tag_checker.sv
// Combinational tag check for one combined beat.
//   i_ch           : packed channel tags {ch4..ch0}
//   o_consistent_c : ch0 is a valid index and every chk == ch0 + k*CH_PER_STREAM
//   o_idx_c        : sample index of the beat (low bits of ch0)
module raw_tag_checker
  import xike_pkg::*;
(
  input  logic [CH_W-1:0] i_ch,
  output logic            o_consistent_c,
  output logic [IW-1:0]   o_idx_c
);

  logic [CW-1:0] w_ch0;

  assign w_ch0   = get_tag(i_ch, 0);
  assign o_idx_c = w_ch0[IW-1:0];

  // Stream k carries channel numbers offset by k frames of CH_PER_STREAM.
  always_comb begin
    o_consistent_c = (w_ch0 < CW'(CH_PER_STREAM));
    for (int unsigned k = 1; k < N_STREAMS; k++) begin
      if (get_tag(i_ch, k) != (w_ch0 + CW'(k * CH_PER_STREAM))) begin
        o_consistent_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/raw_frame_sequencer.sv
// Frame sequencer behind the raw combiner: hunts for sample index 0, checks
// channel tags on every beat and forwards whole frames with index/last/frame
// number through a one-deep output register.
//   bus_clk, aresetn        : clock, async active-low reset
//   enable                  : 1 = acquire frames (acts on frame boundaries)
//   in_valid/in_ready       : combined beat handshake, in_data/in_ch payload
//   out_valid/out_ready     : output beat handshake
//   out_data/out_idx/out_last/out_frame_no : registered output beat
//   locked                  : state == RUN
//   sync_err / sync_err_cnt : mismatch pulse / saturating mismatch count
//   frame_cnt               : completed frames, wrapping
module raw_frame_sequencer
  import xike_pkg::*;
(
  input  logic              bus_clk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_frame_no,
  output logic              locked,
  output logic              sync_err,
  output logic [ERR_W-1:0]  sync_err_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [IW-1:0]    LAST_IDX = IW'(CH_PER_STREAM - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           r_state;
  logic [IW-1:0]    r_idx_cnt;
  logic [CNT_W-1:0] r_frame_no;

  logic          w_consistent;
  logic [IW-1:0] w_idx;
  logic          w_out_free;
  logic          w_is_start;
  logic          w_run_ok;
  logic          w_accept;

  raw_tag_checker u_tag_checker (
    .i_ch           (in_ch),
    .o_consistent_c (w_consistent),
    .o_idx_c        (w_idx)
  );

  assign w_out_free = !out_valid || out_ready;
  assign w_is_start = w_consistent && (w_idx == '0);
  assign w_run_ok   = w_consistent && (w_idx == r_idx_cnt);
  assign w_accept   = in_valid && in_ready;
  assign locked     = (r_state == RUN);

  // IDLE/HUNT discard freely, but a frame-start beat in HUNT waits for the
  // output register so a still-pending beat is never overwritten.
  always_comb begin
    in_ready = 1'b1;
    case (r_state)
      RUN:     in_ready = w_out_free;
      HUNT:    in_ready = w_out_free || !w_is_start;
      default: in_ready = 1'b1;
    endcase
  end

  // State machine, output register and counters.
  always_ff @(posedge bus_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_idx_cnt    <= '0;
      r_frame_no   <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      out_last     <= 1'b0;
      out_frame_no <= '0;
      sync_err     <= 1'b0;
      sync_err_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      sync_err <= 1'b0;

      // Transfer without a new load empties the register; a load below wins.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state    <= HUNT;
            r_frame_no <= '0;
          end
        end

        HUNT: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_accept && w_is_start) begin
            out_valid    <= 1'b1;
            out_data     <= in_data;
            out_idx      <= w_idx;
            out_last     <= (w_idx == LAST_IDX);
            out_frame_no <= r_frame_no;
            r_idx_cnt    <= IW'(1);
            r_state      <= RUN;
          end
        end

        RUN: begin
          if (w_accept) begin
            if (w_run_ok) begin
              out_valid    <= 1'b1;
              out_data     <= in_data;
              out_idx      <= w_idx;
              out_last     <= (w_idx == LAST_IDX);
              out_frame_no <= r_frame_no;
              r_idx_cnt    <= r_idx_cnt + IW'(1);
              // Frame boundary: the only point where enable is honoured.
              if (r_idx_cnt == LAST_IDX) begin
                frame_cnt  <= frame_cnt + CNT_W'(1);
                r_frame_no <= r_frame_no + CNT_W'(1);
                r_state    <= enable ? RUN : IDLE;
              end
            end else begin
              // Broken frame: drop the beat and resynchronise.
              sync_err <= 1'b1;
              if (sync_err_cnt != ERR_MAX) begin
                sync_err_cnt <= sync_err_cnt + ERR_W'(1);
              end
              r_state <= HUNT;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raw_frame_sequencer.sv
// Directed bench for raw_frame_sequencer: tag-check vector table plus
// hand-written frame sequences, with an expected-beat queue checked on
// every output transfer.
module tb_raw_frame_sequencer;

  logic        bus_clk;
  logic        aresetn;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_data;
  logic [59:0] in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [31:0] out_frame_no;
  logic        locked;
  logic        sync_err;
  logic [15:0] sync_err_cnt;
  logic [31:0] frame_cnt;

  raw_frame_sequencer dut (
    .bus_clk      (bus_clk),
    .aresetn      (aresetn),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ch        (in_ch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .out_frame_no (out_frame_no),
    .locked       (locked),
    .sync_err     (sync_err),
    .sync_err_cnt (sync_err_cnt),
    .frame_cnt    (frame_cnt)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic [79:0] data;
    logic [4:0]  idx;
    logic        last;
    logic [31:0] fno;
  } exp_t;

  typedef struct {
    logic [59:0] ch;
    bit          lock;
  } tagvec_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          xfer_cnt = 0;
  int unsigned seq      = 0;
  bit          tog_en   = 0;
  bit          prev_stall = 0;
  logic [79:0] prev_data;
  logic [4:0]  prev_idx;
  tagvec_t     tv[7];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [79:0] mk_data(input int unsigned s);
    logic [79:0] d;
    for (int k = 0; k < 5; k++) d[k*16 +: 16] = 16'(s * 5 + k);
    return d;
  endfunction

  function automatic logic [59:0] mk5(input int c0, input int c1, input int c2,
                                      input int c3, input int c4);
    return {12'(c4), 12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  function automatic logic [59:0] mk_ch(input int i);
    return mk5(i, i + 32, i + 64, i + 96, i + 128);
  endfunction

  // One clock; optionally toggles out_ready right after the edge.
  task automatic tick();
    @(posedge bus_clk);
    #1;
    if (tog_en) out_ready = !out_ready;
  endtask

  // Drive one beat until accepted; queue it as expected output when fwd=1.
  task automatic send(input logic [59:0] ch, input bit fwd, input logic [31:0] fno);
    exp_t e;
    bit   acc;
    in_data  = mk_data(seq);
    seq++;
    in_ch    = ch;
    in_valid = 1'b1;
    if (fwd) begin
      e.data = in_data;
      e.idx  = ch[4:0];
      e.last = (ch[4:0] == 5'd31);
      e.fno  = fno;
      q.push_back(e);
    end
    acc = 0;
    for (int t = 0; t < 64 && !acc; t++) begin
      #1;
      acc = in_ready;
      tick();
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for ch0=%0d", ch[11:0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit fwd, input logic [31:0] fno);
    for (int i = lo; i <= hi; i++) send(mk_ch(i), fwd, fno);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && q.size() != 0; t++) tick();
    chk({"drain ", name}, 80'(q.size()), 80'(0));
  endtask

  // Reset, then enable and step into HUNT.
  task automatic restart();
    aresetn = 1'b0;
    enable  = 1'b1;
    tick();
    aresetn = 1'b1;
    tick();
    tick();
  endtask

  // Output monitor: transfers are decided at the next posedge, sampled here.
  always @(negedge bus_clk) begin
    if (!aresetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 80'(out_valid), 80'(1));
        chk("stall_data", out_data, prev_data);
        chk("stall_idx", 80'(out_idx), 80'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: idx %0d with nothing expected", out_idx);
        end else begin
          mon_e = q.pop_front();
          chk("out_data", out_data, mon_e.data);
          chk("out_idx", 80'(out_idx), 80'(mon_e.idx));
          chk("out_last", 80'(out_last), 80'(mon_e.last));
          chk("out_frame_no", 80'(out_frame_no), 80'(mon_e.fno));
          xfer_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end
  end

  initial begin
    aresetn   = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ch     = '0;
    out_ready = 1'b1;

    tv[0] = '{mk5(0, 32, 64, 96, 128), 1};
    tv[1] = '{mk5(0, 32, 64, 96, 129), 0};
    tv[2] = '{mk5(1, 33, 65, 97, 129), 0};
    tv[3] = '{mk5(32, 64, 96, 128, 160), 0};
    tv[4] = '{mk5(0, 32, 64, 97, 128), 0};
    tv[5] = '{mk5(0, 0, 0, 0, 0), 0};
    tv[6] = '{mk5(31, 63, 95, 127, 159), 0};

    // Reset values
    #12;
    chk("rst out_valid", 80'(out_valid), 80'(0));
    chk("rst out_data", out_data, 80'(0));
    chk("rst out_idx", 80'(out_idx), 80'(0));
    chk("rst out_last", 80'(out_last), 80'(0));
    chk("rst out_frame_no", 80'(out_frame_no), 80'(0));
    chk("rst locked", 80'(locked), 80'(0));
    chk("rst sync_err", 80'(sync_err), 80'(0));
    chk("rst sync_err_cnt", 80'(sync_err_cnt), 80'(0));
    chk("rst frame_cnt", 80'(frame_cnt), 80'(0));

    // Tag-check table: one beat offered in HUNT, lock only on a clean index 0
    foreach (tv[i]) begin
      restart();
      send(tv[i].ch, tv[i].lock, 32'd0);
      chk($sformatf("tag%0d locked", i), 80'(locked), 80'(tv[i].lock));
      chk($sformatf("tag%0d out_valid", i), 80'(out_valid), 80'(tv[i].lock));
      tick();
    end
    drain("tagtable");

    // 1: mid-frame start, then two clean frames
    aresetn = 1'b0;
    enable  = 1'b0;
    tick();
    aresetn = 1'b1;
    enable  = 1'b1;
    tick();
    tick();
    send_range(17, 31, 0, 0);
    chk("t1 locked before start", 80'(locked), 80'(0));
    send(mk_ch(0), 1, 32'd0);
    chk("t1 locked at start", 80'(locked), 80'(1));
    send_range(1, 31, 1, 0);
    send_range(0, 31, 1, 1);
    drain("t1");
    chk("t1 frame_cnt", 80'(frame_cnt), 80'(2));
    chk("t1 locked", 80'(locked), 80'(1));

    // 2: index 9 replaced by 10
    send_range(0, 8, 1, 2);
    send(mk_ch(10), 0, 0);
    chk("t2 sync_err", 80'(sync_err), 80'(1));
    chk("t2 sync_err_cnt", 80'(sync_err_cnt), 80'(1));
    chk("t2 locked", 80'(locked), 80'(0));
    send(mk_ch(11), 0, 0);
    chk("t2 sync_err pulse", 80'(sync_err), 80'(0));
    send_range(12, 31, 0, 0);
    send_range(0, 31, 1, 2);
    drain("t2");
    chk("t2 frame_cnt", 80'(frame_cnt), 80'(3));

    // 3: single bad tag (ch2) inside a running frame
    send_range(0, 4, 1, 3);
    send(mk5(5, 37, 70, 101, 133), 0, 0);
    chk("t3 sync_err", 80'(sync_err), 80'(1));
    chk("t3 sync_err_cnt", 80'(sync_err_cnt), 80'(2));
    chk("t3 locked", 80'(locked), 80'(0));
    send_range(6, 31, 0, 0);
    send_range(0, 31, 1, 3);
    drain("t3");
    chk("t3 frame_cnt", 80'(frame_cnt), 80'(4));

    // 4: enable dropped mid-frame, frame still completes
    send_range(0, 12, 1, 4);
    enable = 1'b0;
    send_range(13, 31, 1, 4);
    chk("t4 locked after last", 80'(locked), 80'(0));
    chk("t4 frame_cnt", 80'(frame_cnt), 80'(5));
    send_range(0, 3, 0, 0);
    chk("t4 out_valid idle", 80'(out_valid), 80'(0));
    drain("t4");

    // 5: out_ready toggling every cycle over a full frame
    enable = 1'b1;
    tick();
    tick();
    xfer_cnt = 0;
    tog_en   = 1;
    send_range(0, 31, 1, 0);
    drain("t5");
    tog_en    = 0;
    out_ready = 1'b1;
    tick();
    chk("t5 transfers", 80'(xfer_cnt), 80'(32));
    chk("t5 frame_cnt", 80'(frame_cnt), 80'(6));

    // 6: asynchronous reset with a beat pending at index 20
    send_range(0, 19, 1, 1);
    send(mk_ch(20), 0, 0);
    chk("t6 pending before reset", 80'(out_valid), 80'(1));
    #1;
    aresetn = 1'b0;
    #1;
    chk("t6 out_valid", 80'(out_valid), 80'(0));
    chk("t6 out_data", out_data, 80'(0));
    chk("t6 out_idx", 80'(out_idx), 80'(0));
    chk("t6 locked", 80'(locked), 80'(0));
    chk("t6 frame_cnt", 80'(frame_cnt), 80'(0));
    chk("t6 sync_err_cnt", 80'(sync_err_cnt), 80'(0));
    chk("t6 out_frame_no", 80'(out_frame_no), 80'(0));
    tick();
    aresetn = 1'b1;
    tick();
    tick();
    chk("t6 hunting", 80'(locked), 80'(0));
    send_range(21, 31, 0, 0);
    send_range(0, 31, 1, 0);
    drain("t6");
    chk("t6 frame_cnt after", 80'(frame_cnt), 80'(1));
    chk("t6 frame_no after", 80'(out_frame_no), 80'(0));
    chk("t6 relocked", 80'(locked), 80'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
